// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 opcodes, funct3 codes, exception causes and memory-stage states
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Opcodes whose result goes to rd (when rd is not x0).
    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
               (opc == OPC_JALR) || (opc == OPC_OP) || (opc == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane steering, load extension and access legality checks
// Ports:
//   is_store   in  1 : 1 = evaluate as store, 0 = evaluate as load
//   funct3     in  3 : access size/sign code
//   addr_lo    in  2 : low address bits selecting the byte lane
//   store_data in 32 : rs2 value to be steered onto the bus
//   rdata      in 32 : raw word returned by memory
//   be         out 4 : store byte enables (0 for loads)
//   wdata      out 32: lane-replicated store data
//   load_data  out 32: selected and extended load value
//   misaligned out 1 : halfword/word address not naturally aligned
//   illegal    out 1 : funct3 not a valid code for this access direction
module mem_align
    import rv32_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (is_store) begin
            unique case (funct3)
                F3_B: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    be         = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata      = {2{store_data[15:0]}};
                    misaligned = addr_lo[0];
                end
                F3_W: begin
                    be         = 4'b1111;
                    wdata      = store_data;
                    misaligned = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                F3_BU: load_data = {24'h0, shifted[7:0]};
                F3_H: begin
                    load_data  = {{16{shifted[15]}}, shifted[15:0]};
                    misaligned = addr_lo[0];
                end
                F3_HU: begin
                    load_data  = {16'h0, shifted[15:0]};
                    misaligned = addr_lo[0];
                end
                F3_W: begin
                    load_data  = rdata;
                    misaligned = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/memory_ctl.sv
// rtl/memory_ctl.sv - memory-access stage: dmem req/ack port, stall, writeback registers
// Ports:
//   clk, rst (async, active-low)
//   valid_exe, alu_result, data_b_exe, pc_exe, instr_exe : instruction from execute
//   stall                                                : hold execute and upstream
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata            : data-memory port
//   wb_valid/we/rd/data, pc_mem, instr_mem, exc          : writeback stage outputs
module memory_ctl
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_exe,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_b_exe,
    input  logic [31:0] pc_exe,
    input  logic [31:0] instr_exe,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] pc_mem,
    output logic [31:0] instr_mem,
    output logic [1:0]  exc
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [6:0]  opcode;
    logic        exe_load, exe_store, in_idle;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load_data;
    logic        al_misaligned, al_illegal;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    // Context of the outstanding access, so retirement does not depend on execute holding still.
    logic [1:0]  alo_q, alo_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
    logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d, pc_mem_q, pc_mem_d, instr_mem_q, instr_mem_d;
    logic [1:0]  exc_q, exc_d;

    assign opcode    = instr_exe[6:0];
    assign exe_load  = (opcode == OPC_LOAD);
    assign exe_store = (opcode == OPC_STORE);
    assign in_idle   = (state_q == ST_IDLE);

    // In IDLE the aligner checks/steers the incoming access; in REQ it extracts the load result.
    mem_align u_align (
        .is_store   (in_idle & exe_store),
        .funct3     (in_idle ? instr_exe[14:12] : instr_q[14:12]),
        .addr_lo    (in_idle ? alu_result[1:0] : alo_q),
        .store_data (data_b_exe),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load_data),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        alo_d        = alo_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        pc_mem_d     = pc_mem_q;
        instr_mem_d  = instr_mem_q;
        exc_d        = exc_q;
        stall        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_exe) begin
                    if ((exe_load || exe_store) && !(al_illegal || al_misaligned)) begin
                        stall        = 1'b1;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = exe_store;
                        dmem_addr_d  = {alu_result[31:2], 2'b00};
                        dmem_be_d    = exe_store ? al_be : 4'b0000;
                        dmem_wdata_d = exe_store ? al_wdata : 32'h0;
                        cnt_d        = 8'd0;
                        alo_d        = alu_result[1:0];
                        pc_d         = pc_exe;
                        instr_d      = instr_exe;
                        state_d      = ST_REQ;
                    end else begin
                        // ALU ops and faulted accesses retire on the next edge; a fault does not
                        // stall, so execute moves past the offending instruction.
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = instr_exe[11:7];
                        pc_mem_d    = pc_exe;
                        instr_mem_d = instr_exe;
                        wb_data_d   = ((opcode == OPC_JAL) || (opcode == OPC_JALR)) ?
                                      pc_exe + 32'd4 : alu_result;
                        if (exe_load || exe_store) begin
                            wb_we_d = 1'b0;
                            exc_d   = al_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                        end else begin
                            wb_we_d = writes_rd(opcode) && (instr_exe[11:7] != 5'd0);
                            exc_d   = EXC_NONE;
                        end
                    end
                end
            end
            ST_REQ: begin
                wb_rd_d     = instr_q[11:7];
                pc_mem_d    = pc_q;
                instr_mem_d = instr_q;
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !dmem_we_q && (instr_q[11:7] != 5'd0);
                    wb_data_d  = dmem_we_q ? 32'h0 : al_load_data;
                    exc_d      = EXC_NONE;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_data_d  = 32'h0;
                    exc_d      = EXC_TIMEOUT;
                    state_d    = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= 32'h0;
            alo_q        <= 2'b00;
            pc_q         <= 32'h0;
            instr_q      <= 32'h0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'h0;
            pc_mem_q     <= 32'h0;
            instr_mem_q  <= 32'h0;
            exc_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            alo_q        <= alo_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            pc_mem_q     <= pc_mem_d;
            instr_mem_q  <= instr_mem_d;
            exc_q        <= exc_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign pc_mem     = pc_mem_q;
    assign instr_mem  = instr_mem_q;
    assign exc        = exc_q;

endmodule

// File: tb/tb_memory_ctl.sv
// tb/tb_memory_ctl.sv - randomized self-checking bench for memory_ctl against a transaction-level model
module tb_memory_ctl;

    localparam int TO = 4;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_exe;
    logic [31:0] alu_result, data_b_exe, pc_exe, instr_exe;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, pc_mem, instr_mem;
    logic [1:0]  exc;

    always #5 clk = ~clk;

    memory_ctl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_exe(valid_exe), .alu_result(alu_result),
        .data_b_exe(data_b_exe), .pc_exe(pc_exe), .instr_exe(instr_exe), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_mem(pc_mem), .instr_mem(instr_mem), .exc(exc)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Per-cycle expectations, set by the driver from the model before the checking edge.
    logic        exp_stall, exp_req, exp_dwe;
    logic [31:0] exp_daddr, exp_dwdata;
    logic [3:0]  exp_be;
    logic        exp_wbv, exp_wwe, exp_wdchk;
    logic [4:0]  exp_wrd;
    logic [31:0] exp_wbdata, exp_pc, exp_instr;
    logic [1:0]  exp_exc;

    // Retirement decided this cycle, visible on the writeback outputs next cycle.
    logic        pend_v, pend_we, pend_chk;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data, pend_pc, pend_instr;
    logic [1:0]  pend_exc;

    // Observations kept for the literal directed checks.
    int          stall_total = 0;
    int          req_total = 0;
    logic [31:0] last_wb_data, last_addr, last_wdata;
    logic [3:0]  last_be;
    logic [1:0]  last_exc;
    logic        last_wb_we;

    logic [6:0] nonmem_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                   7'b0110011, 7'b0010011, 7'b1100011, 7'b0001111, 7'b1110011};
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("stall", 32'(stall), 32'(exp_stall));
                chk("dmem_req", 32'(dmem_req), 32'(exp_req));
                if (exp_req) begin
                    chk("dmem_we", 32'(dmem_we), 32'(exp_dwe));
                    chk("dmem_addr", dmem_addr, exp_daddr);
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    if (exp_dwe) chk("dmem_wdata", dmem_wdata, exp_dwdata);
                end
                chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
                if (exp_wbv) begin
                    chk("wb_we", 32'(wb_we), 32'(exp_wwe));
                    chk("wb_rd", 32'(wb_rd), 32'(exp_wrd));
                    chk("pc_mem", pc_mem, exp_pc);
                    chk("instr_mem", instr_mem, exp_instr);
                    chk("exc", 32'(exc), 32'(exp_exc));
                    if (exp_wdchk) chk("wb_data", wb_data, exp_wbdata);
                    last_wb_data = wb_data;
                    last_exc     = exc;
                    last_wb_we   = wb_we;
                end
                if (stall) stall_total++;
                if (dmem_req) begin
                    req_total++;
                    last_addr  = dmem_addr;
                    last_be    = dmem_be;
                    last_wdata = dmem_wdata;
                end
            end
        end
    endtask

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
        logic [7:0]  by;
        logic [15:0] hw;
        by = d[8*a +: 8];
        hw = d[16*a[1] +: 16];
        case (f3)
            3'd0:    return 32'($signed(by));
            3'd4:    return {24'h0, by};
            3'd1:    return 32'($signed(hw));
            3'd5:    return {16'h0, hw};
            default: return d;
        endcase
    endfunction

    task automatic set_pend(input logic we, input logic [4:0] rd, input logic dchk,
                            input logic [31:0] data, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [1:0] ex);
        pend_v = 1'b1; pend_we = we; pend_rd = rd; pend_chk = dchk;
        pend_data = data; pend_pc = pc; pend_instr = ins; pend_exc = ex;
    endtask

    task automatic load_wb();
        exp_wbv = pend_v; exp_wwe = pend_we; exp_wrd = pend_rd; exp_wdchk = pend_chk;
        exp_wbdata = pend_data; exp_pc = pend_pc; exp_instr = pend_instr; exp_exc = pend_exc;
        pend_v = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        load_wb();
        valid_exe  = 1'b0;
        instr_exe  = $urandom;
        alu_result = $urandom;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        exp_stall  = 1'b0;
        exp_req    = 1'b0;
        tick();
    endtask

    // One instruction from presentation in execute until it leaves; lat = REQ cycle carrying ack.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                             input logic [31:0] addr, input logic [31:0] b, input int lat,
                             input logic [31:0] rdata);
        logic [31:0] ins, pc, wd;
        logic [3:0]  be;
        bit is_ld, is_st, ill, mis, ack, tmo, wr;
        int size, a;
        ins = $urandom;
        ins[6:0] = opc; ins[11:7] = rd; ins[14:12] = f3;
        pc = $urandom & 32'hFFFF_FFFC;
        is_ld = (opc == LOAD);
        is_st = (opc == STORE);
        ill = is_ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) :
              is_st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : 1'b0;
        size = 1 << f3[1:0];
        a = int'(addr[1:0]);
        mis = (is_ld || is_st) && !ill && (a % size != 0);
        load_wb();
        valid_exe = 1'b1; instr_exe = ins; pc_exe = pc; alu_result = addr; data_b_exe = b;
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        exp_req = 1'b0;
        exp_stall = (is_ld || is_st) && !ill && !mis;
        if (!(is_ld || is_st)) begin
            wr = (opc inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                              7'b0110011, 7'b0010011}) && (rd != 0);
            set_pend(wr, rd, 1'b1,
                     (opc == 7'b1101111 || opc == 7'b1100111) ? pc + 4 : addr, pc, ins, 2'd0);
            tick();
            return;
        end
        if (ill || mis) begin
            set_pend(1'b0, rd, 1'b0, 32'h0, pc, ins, ill ? 2'd3 : 2'd1);
            tick();
            return;
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            be[i] = is_st && (i >= a) && (i < a + size);
            wd[8*i +: 8] = b[8*(i % size) +: 8];
        end
        for (int k = 1; k <= TO + 8; k++) begin
            load_wb();
            ack = (k == lat);
            tmo = (k == TO) && !ack;
            exp_req = 1'b1; exp_dwe = is_st; exp_daddr = addr & 32'hFFFF_FFFC;
            exp_be = be; exp_dwdata = wd;
            exp_stall = !(ack || tmo);
            dmem_ack = ack;
            dmem_rdata = ack ? rdata : $urandom;
            if (ack) set_pend(is_ld && rd != 0, rd, is_ld, ld_ext(f3, addr[1:0], rdata), pc, ins, 2'd0);
            else if (tmo) set_pend(1'b0, rd, 1'b0, 32'h0, pc, ins, 2'd2);
            tick();
            if (ack || tmo) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        pend_v = 1'b0; pend_we = 1'b0; pend_rd = '0; pend_chk = 1'b0;
        pend_data = '0; pend_pc = '0; pend_instr = '0; pend_exc = '0;
        rst = 1'b0; valid_exe = 1'b0; alu_result = '0; data_b_exe = '0; pc_exe = '0;
        instr_exe = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        fork compare_loop(); join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_pc_mem", pc_mem, 32'd0);
        chk("rst_instr_mem", instr_mem, 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk_en = 1'b1;
        idle_cycle();

        // ADDI x5 with result 0x1234, never stalls.
        s0 = stall_total;
        run_instr(OPIMM, 3'd0, 5'd5, 32'h1234, 32'h0, 1, 32'h0);
        idle_cycle();
        chk("addi_wb_data", last_wb_data, 32'h0000_1234);
        chk("addi_stall_cycles", 32'(stall_total - s0), 32'd0);

        // SB to 0x103, ack on the 4th REQ cycle (same cycle the timeout would fire).
        s0 = stall_total;
        run_instr(STORE, 3'd0, 5'd9, 32'h103, 32'h0000_00AB, 4, 32'h0);
        idle_cycle();
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_addr", last_addr, 32'h0000_0100);
        chk("sb_stall_cycles", 32'(stall_total - s0), 32'd4);
        chk("sb_exc", 32'(last_exc), 32'd0);
        chk("sb_wb_we", 32'(last_wb_we), 32'd0);

        run_instr(LOAD, 3'd0, 5'd7, 32'h102, 32'h0, 1, 32'h0080_0000);
        idle_cycle();
        chk("lb_sign", last_wb_data, 32'hFFFF_FF80);
        run_instr(LOAD, 3'd4, 5'd7, 32'h102, 32'h0, 1, 32'h0080_0000);
        idle_cycle();
        chk("lbu_zero", last_wb_data, 32'h0000_0080);

        r0 = req_total;
        run_instr(LOAD, 3'd2, 5'd7, 32'h102, 32'h0, 1, 32'h0);
        idle_cycle();
        chk("lw_misalign_exc", 32'(last_exc), 32'd1);
        chk("lw_misalign_noreq", 32'(req_total - r0), 32'd0);

        r0 = req_total;
        run_instr(LOAD, 3'd2, 5'd7, 32'h200, 32'h0, 1000, 32'h0);
        idle_cycle();
        chk("lw_timeout_exc", 32'(last_exc), 32'd2);
        chk("lw_timeout_req_cycles", 32'(req_total - r0), 32'd4);

        // Reset pulsed mid-REQ: req must fall before the next edge, nothing retires.
        load_wb();
        valid_exe = 1'b1; instr_exe = {17'h0, 3'd2, 5'd3, LOAD}; pc_exe = 32'h40;
        alu_result = 32'h300; dmem_ack = 1'b0; exp_stall = 1'b1; exp_req = 1'b0;
        tick();
        #2;
        chk_en = 1'b0;
        chk("reset_pre_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("reset_async_req_drop", 32'(dmem_req), 32'd0);
        chk("reset_no_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pend_v = 1'b0;
        chk_en = 1'b1;
        idle_cycle();
        idle_cycle();
        run_instr(LOAD, 3'd2, 5'd3, 32'h300, 32'h0, 2, 32'hCAFE_F00D);
        idle_cycle();
        chk("post_reset_lw", last_wb_data, 32'hCAFE_F00D);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 9) < 4) begin
                opc = nonmem_ops[$urandom_range(0, 8)];
                run_instr(opc, 3'($urandom), rd, addr, $urandom, 1, 32'h0);
            end else begin
                opc = ($urandom_range(0, 1) == 0) ? LOAD : STORE;
                if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
                else if (opc == LOAD) f3 = ld_f3[$urandom_range(0, 4)];
                else f3 = st_f3[$urandom_range(0, 2)];
                run_instr(opc, f3, rd, addr, $urandom, $urandom_range(1, TO + 2), $urandom);
            end
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
